uart_tx_arbiter: RTL and testbench

Shares one `uart_transmitter` between `NUM_REQ` byte producers. Each producer's byte is granted in round-robin order. For each grant the block issues a one-cycle start pulse with a stable data byte to the transmitter. The transmitter has no done/ready output, so the block times each frame with an internal counter and holds off the next start until the frame has finished.

---
 rtl/uart_tx_arbiter.sv | 133 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter between NUM_REQ byte producers.
// The transmitter has no done flag, so each frame is timed with an internal down-counter.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned CYCLES_PER_BIT = 21812,
  parameter int unsigned GUARD_CYCLES   = 2
) (
  input  logic                       clk,
  input  logic                       r_reset,
  input  logic [NUM_REQ-1:0]         i_req,
  input  logic [8*NUM_REQ-1:0]       i_data,
  output logic [NUM_REQ-1:0]         o_ack,
  output logic                       o_tx_start,
  output logic [7:0]                 o_tx_data,
  output logic [$clog2(NUM_REQ)-1:0] o_grant_id,
  output logic                       o_busy
);

  localparam int unsigned FRAME_CYCLES = 10 * CYCLES_PER_BIT + GUARD_CYCLES;
  localparam int unsigned CNT_W        = $clog2(FRAME_CYCLES);
  localparam int unsigned ID_W         = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [ID_W-1:0]    grant_q, grant_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic               start_q, start_d;
  logic               busy_q, busy_d;
  logic [7:0]         data_q, data_d;

  logic               found;
  logic [ID_W-1:0]    sel;
  logic [7:0]         data_pick;

  // First set request at or after ptr_q, wrapping modulo NUM_REQ.
  always_comb begin : pick
    int unsigned    idx32;
    logic [ID_W-1:0] idx;
    found = 1'b0;
    sel   = '0;
    idx32 = 0;
    idx   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx32 = 32'(ptr_q) + i;
      if (idx32 >= NUM_REQ) begin
        idx32 = idx32 - NUM_REQ;
      end
      idx = ID_W'(idx32);
      if (!found && i_req[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
    data_pick = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (ID_W'(k) == sel) begin
        data_pick = i_data[8*k +: 8];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    data_d  = data_q;
    ack_d   = '0;
    start_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d = S_LAUNCH;
          grant_d = sel;
          data_d  = data_pick;
          ack_d   = NUM_REQ'(1) << sel;
          start_d = 1'b1;
        end
      end
      S_LAUNCH: begin
        ptr_d   = (grant_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
        cnt_d   = CNT_W'(FRAME_CYCLES - 1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Registered so o_busy tracks the state the flops are about to enter.
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (r_reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      grant_q <= '0;
      data_q  <= '0;
      ack_q   <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      data_q  <= data_d;
      ack_q   <= ack_d;
      start_q <= start_d;
      busy_q  <= busy_d;
    end
  end

  assign o_ack      = ack_q;
  assign o_tx_start = start_q;
  assign o_tx_data  = data_q;
  assign o_grant_id = grant_q;
  assign o_busy     = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus randomized producers, checked every
// cycle against a timing-rule model of grants, round-robin order and frame length.
module tb_uart_tx_arbiter;

  localparam int NR    = 4;
  localparam int CPB   = 4;
  localparam int GC    = 2;
  localparam int FRAME = 10 * CPB + GC;

  logic        clk = 1'b0;
  logic        r_reset;
  logic [3:0]  i_req;
  logic [31:0] i_data;
  logic [3:0]  o_ack;
  logic        o_tx_start;
  logic [7:0]  o_tx_data;
  logic [1:0]  o_grant_id;
  logic        o_busy;

  uart_tx_arbiter #(
    .NUM_REQ        (NR),
    .CYCLES_PER_BIT (CPB),
    .GUARD_CYCLES   (GC)
  ) dut (
    .clk        (clk),
    .r_reset    (r_reset),
    .i_req      (i_req),
    .i_data     (i_data),
    .o_ack      (o_ack),
    .o_tx_start (o_tx_start),
    .o_tx_data  (o_tx_data),
    .o_grant_id (o_grant_id),
    .o_busy     (o_busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference: a grant happens at IDLE cycle T, the block is free again at T+2+FRAME.
  int         cyc = 0;
  int         idle_at = 0;
  int         ptr = 0;
  logic [3:0] e_ack;
  logic       e_start;
  logic [7:0] e_data;
  logic [1:0] e_gid;
  logic       e_busy;
  bit         auto_drop = 1'b1;
  int         busy_cnt;
  int         st_cyc[$];
  int         st_gid[$];
  int         st_dat[$];

  task automatic step();
    int g;
    @(posedge clk);
    if (r_reset) begin
      e_ack = '0; e_start = 1'b0; e_data = '0; e_gid = '0; e_busy = 1'b0;
      idle_at = cyc + 1;
      ptr = 0;
    end else if (cyc >= idle_at && i_req != 4'b0) begin
      g = -1;
      for (int i = 0; i < NR; i++) begin
        if (g < 0 && i_req[(ptr + i) % NR]) g = (ptr + i) % NR;
      end
      e_ack   = 4'(1 << g);
      e_start = 1'b1;
      e_data  = i_data[8*g +: 8];
      e_gid   = 2'(g);
      e_busy  = 1'b1;
      idle_at = cyc + 2 + FRAME;
      ptr     = (g + 1) % NR;
    end else begin
      e_ack   = '0;
      e_start = 1'b0;
      e_busy  = (cyc + 1 < idle_at);
    end
    cyc++;
    #1;
    chk("ack",   o_ack,      e_ack);
    chk("start", o_tx_start, e_start);
    chk("data",  o_tx_data,  e_data);
    chk("gid",   o_grant_id, e_gid);
    chk("busy",  o_busy,     e_busy);
    if (o_tx_start) begin
      st_cyc.push_back(cyc);
      st_gid.push_back(int'(o_grant_id));
      st_dat.push_back(int'(o_tx_data));
    end
    if (o_busy) busy_cnt++;
    if (auto_drop) i_req = i_req & ~e_ack;
  endtask

  task automatic do_reset();
    r_reset = 1'b1;
    step();
    r_reset = 1'b0;
    step();
  endtask

  task automatic clear_log();
    st_cyc.delete();
    st_gid.delete();
    st_dat.delete();
    busy_cnt = 0;
  endtask

  initial begin
    r_reset = 1'b1;
    i_req   = '0;
    i_data  = '0;
    repeat (3) step();
    r_reset = 1'b0;
    repeat (2) step();

    // 1: single request from requester 1
    i_data = 32'h0000A500;
    i_req  = 4'b0010;
    clear_log();
    step();
    chk("t1_ack",   o_ack,      4'b0010);
    chk("t1_start", o_tx_start, 1'b1);
    chk("t1_data",  o_tx_data,  8'hA5);
    chk("t1_gid",   o_grant_id, 2'd1);
    repeat (60) step();
    chk("t1_busy_len", busy_cnt, 43);

    // 2: all four held high
    do_reset();
    auto_drop = 1'b0;
    i_data = 32'h44332211;
    i_req  = 4'hF;
    clear_log();
    repeat (190) step();
    chk("t2_count_ge5", st_cyc.size() >= 5, 1);
    if (st_cyc.size() >= 5) begin
      chk("t2_g0", st_gid[0], 0);
      chk("t2_g1", st_gid[1], 1);
      chk("t2_g2", st_gid[2], 2);
      chk("t2_g3", st_gid[3], 3);
      chk("t2_g4", st_gid[4], 0);
      for (int i = 0; i < 4; i++) chk("t2_spacing", st_cyc[i+1] - st_cyc[i], 44);
    end
    i_req = '0;
    repeat (50) step();

    // 3: fairness between requesters 0 and 2
    do_reset();
    i_data = 32'h00220011;
    i_req  = 4'b0101;
    clear_log();
    repeat (4 * 44 + 5) step();
    chk("t3_count_ge4", st_cyc.size() >= 4, 1);
    if (st_cyc.size() >= 4) begin
      chk("t3_g0", st_gid[0], 0); chk("t3_d0", st_dat[0], 32'h11);
      chk("t3_g1", st_gid[1], 2); chk("t3_d1", st_dat[1], 32'h22);
      chk("t3_g2", st_gid[2], 0); chk("t3_d2", st_dat[2], 32'h11);
      chk("t3_g3", st_gid[3], 2); chk("t3_d3", st_dat[3], 32'h22);
    end
    i_req = '0;
    repeat (50) step();

    // 4: reset 20 cycles into WAIT with requesters 0 and 3 pending
    do_reset();
    i_data = 32'h99000088;
    i_req  = 4'b1001;
    step();
    step();
    repeat (20) step();
    r_reset = 1'b1;
    step();
    chk("t4_busy",  o_busy,     1'b0);
    chk("t4_ack",   o_ack,      4'b0);
    chk("t4_start", o_tx_start, 1'b0);
    chk("t4_data",  o_tx_data,  8'h00);
    chk("t4_gid",   o_grant_id, 2'd0);
    r_reset = 1'b0;
    clear_log();
    repeat (3) step();
    chk("t4_first_grant_seen", st_gid.size(), 1);
    if (st_gid.size() >= 1) chk("t4_first_grant", st_gid[0], 0);
    i_req = '0;
    repeat (50) step();

    // 5: request raised and dropped inside WAIT is never acked
    auto_drop = 1'b1;
    i_data = 32'h77000066;
    i_req  = 4'b0001;
    step();
    clear_log();
    repeat (5) step();
    i_req[3] = 1'b1;
    repeat (10) step();
    i_req[3] = 1'b0;
    repeat (50) step();
    chk("t5_no_start", st_cyc.size(), 0);

    // 6: granted requester's data changes right after ack
    i_data = 32'h005A0000;
    i_req  = 4'b0100;
    step();
    chk("t6_ack", o_ack, 4'b0100);
    step();
    i_data = 32'h00C30000;
    repeat (45) step();
    chk("t6_hold", o_tx_data, 8'h5A);

    // Randomized producers with occasional withdrawals and resets
    for (int n = 0; n < 3000; n++) begin
      for (int k = 0; k < NR; k++) begin
        if (!i_req[k] && $urandom_range(0, 9) == 0) begin
          i_data[8*k +: 8] = 8'($urandom);
          i_req[k] = 1'b1;
        end else if (i_req[k] && $urandom_range(0, 199) == 0) begin
          i_req[k] = 1'b0;
        end
      end
      r_reset = ($urandom_range(0, 399) == 0);
      step();
    end
    r_reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
